// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: eight selectable bitwise functions with an optional
// accumulator operand, results plus reduction flags buffered in a DEPTH-entry FIFO.
module bitwise_logic_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [WIDTH-1:0] acc_q,
  output logic [CW-1:0]    count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready depends only on registered occupancy.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam int EW = WIDTH + 3;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NOTB = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] result;
  logic             res_zero;
  logic             res_ones;
  logic             res_parity;
  logic             push;
  logic             pop;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;

  always_comb begin
    opa    = acc_en ? acc_q : a;
    result = '0;
    case (op_e'(op))
      OP_AND:  result = opa & b;
      OP_OR:   result = opa | b;
      OP_NOTA: result = ~opa;
      OP_NOTB: result = ~b;
      OP_NAND: result = ~(opa & b);
      OP_NOR:  result = ~(opa | b);
      OP_XOR:  result = opa ^ b;
      OP_XNOR: result = ~(opa ^ b);
      default: result = '0;
    endcase
  end

  assign res_zero   = (result == '0);
  assign res_ones   = &result;
  assign res_parity = ^result;

  assign in_ready  = rst_n && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {result, res_zero, res_ones, res_parity};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear wins over write-back; the enqueued result still used the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (push && acc_en) begin
      acc_q <= result;
    end
  end

  assign head   = mem[rd_ptr];
  assign y      = out_valid ? head[EW-1:3] : '0;
  assign zero   = out_valid ? head[2] : 1'b0;
  assign ones   = out_valid ? head[1] : 1'b0;
  assign parity = out_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit: a queue-based reference model predicts
// FIFO contents, accumulator and handshake state for two configurations.
module tb_bitwise_logic_unit;

  localparam int D1 = 2;
  localparam int D2 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Configuration 1: WIDTH=8, DEPTH=2
  logic       in_valid = 0, in_ready, acc_en = 0, acc_clr = 0, out_valid, out_ready = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0, y, acc_q;
  logic       zero, ones, parity;
  logic [1:0] count;

  bitwise_logic_unit #(.WIDTH(8), .DEPTH(D1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .ones(ones), .parity(parity),
    .acc_q(acc_q), .count(count)
  );

  // Configuration 2: WIDTH=4, DEPTH=3
  logic       d2_in_valid = 0, d2_in_ready, d2_acc_en = 0, d2_acc_clr = 0;
  logic       d2_out_valid, d2_out_ready = 0;
  logic [2:0] d2_op = 0;
  logic [3:0] d2_a = 0, d2_b = 0, d2_y, d2_acc_q;
  logic       d2_zero, d2_ones, d2_parity;
  logic [1:0] d2_count;

  bitwise_logic_unit #(.WIDTH(4), .DEPTH(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .op(d2_op),
    .acc_en(d2_acc_en), .acc_clr(d2_acc_clr), .a(d2_a), .b(d2_b), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .y(d2_y), .zero(d2_zero), .ones(d2_ones), .parity(d2_parity),
    .acc_q(d2_acc_q), .count(d2_count)
  );

  int checks = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [6:0]  exp_q2[$];
  logic [7:0]  model_acc = 8'h00;

  function automatic logic [7:0] ref_fn(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~x;
      3'd3: return ~z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [10:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : 11'h0;
    chk({tag, ".in_ready"}, in_ready, exp_q.size() < D1);
    chk({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
    chk({tag, ".count"}, count, exp_q.size());
    chk({tag, ".y"}, y, h[10:3]);
    chk({tag, ".flags"}, {zero, ones, parity}, h[2:0]);
    chk({tag, ".acc_q"}, acc_q, model_acc);
  endtask

  // Drive one cycle on configuration 1: check current state, then advance model and DUT.
  task automatic cycle(input string tag, input logic iv, input logic [2:0] o, input logic ae,
                       input logic ac, input logic [7:0] av, input logic [7:0] bv,
                       input logic ordy);
    logic do_acc, do_pop;
    logic [7:0] r;
    in_valid = iv; op = o; acc_en = ae; acc_clr = ac; a = av; b = bv; out_ready = ordy;
    #1;
    check_state(tag);
    do_acc = iv && (exp_q.size() < D1);
    do_pop = ordy && (exp_q.size() > 0);
    r = ref_fn(o, ae ? model_acc : av, bv);
    @(posedge clk); #1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_acc) exp_q.push_back({r, (r == 8'h00), (r == 8'hFF), ^r});
    if (ac) model_acc = 8'h00;
    else if (do_acc && ae) model_acc = r;
    in_valid = 0; acc_clr = 0; acc_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] t3 [4];
    logic [7:0] t3b [4];
    int sent, got;
    t1  = '{8'h81, 8'hE7, 8'h3C, 8'h5A, 8'h7E, 8'h18, 8'h66, 8'h99};
    t3  = '{8'h01, 8'h02, 8'h04, 8'h80};
    t3b = '{8'h01, 8'h03, 8'h07, 8'h87};

    // Reset state while rst_n is held low
    #12;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.count", count, 0);
    chk("rst.y", y, 0);
    chk("rst.flags", {zero, ones, parity}, 0);
    chk("rst.acc_q", acc_q, 0);
    chk("rst.d2_in_ready", d2_in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // 1: opcode sweep
    for (int k = 0; k < 8; k++) begin
      cycle("t1", 1, 3'(k), 0, 0, 8'hC3, 8'hA5, 1);
      chk("t1.y_table", y, t1[k]);
      chk("t1.parity", parity, 0);
      chk("t1.zero_ones", {zero, ones}, 0);
    end
    cycle("t1.drain", 0, 0, 0, 0, 0, 0, 1);

    // 2: backpressure
    cycle("t2.a", 1, 3'd0, 0, 0, 8'hFF, 8'hFF, 0);
    cycle("t2.b", 1, 3'd6, 0, 0, 8'h0F, 8'h0F, 0);
    chk("t2.full_count", count, 2);
    chk("t2.full_in_ready", in_ready, 0);
    chk("t2.head_y", y, 8'hFF);
    chk("t2.head_ones", ones, 1);
    cycle("t2.held", 1, 3'd1, 0, 0, 8'h30, 8'h03, 0);
    chk("t2.held_count", count, 2);
    chk("t2.stable_y", y, 8'hFF);
    cycle("t2.pop1", 1, 3'd1, 0, 0, 8'h30, 8'h03, 1);
    chk("t2.y_zero", y, 8'h00);
    chk("t2.zero_flag", zero, 1);
    cycle("t2.pop2", 1, 3'd1, 0, 0, 8'h30, 8'h03, 1);
    chk("t2.or_result", y, 8'h33);
    cycle("t2.drain", 0, 0, 0, 0, 0, 0, 1);

    // 3: accumulator chain
    cycle("t3.clr", 0, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle("t3.or", 1, 3'd1, 1, 0, 8'h00, t3[k], 1);
      chk("t3.y_chain", y, t3b[k]);
    end
    chk("t3.acc_87", acc_q, 8'h87);
    cycle("t3.clr_xor", 1, 3'd6, 1, 1, 8'h00, 8'hFF, 1);
    chk("t3.y_78", y, 8'h78);
    chk("t3.acc_cleared", acc_q, 8'h00);
    cycle("t3.drain", 0, 0, 0, 0, 0, 0, 1);

    // 4: DEPTH=3, WIDTH=4 streaming with toggling out_ready
    sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 12; c++) begin
      logic dacc, dpop;
      logic [3:0] r4;
      logic [6:0] h2;
      d2_in_valid = (sent < 12);
      d2_op = 3'($urandom_range(0, 7));
      d2_a = 4'($urandom_range(0, 15));
      d2_b = 4'($urandom_range(0, 15));
      d2_out_ready = c[0];
      #1;
      h2 = (exp_q2.size() > 0) ? exp_q2[0] : 7'h0;
      chk("t4.count_max", (d2_count <= 2'd3), 1);
      chk("t4.count", d2_count, exp_q2.size());
      chk("t4.in_ready", d2_in_ready, exp_q2.size() < D2);
      chk("t4.out_valid", d2_out_valid, exp_q2.size() > 0);
      chk("t4.head", {d2_y, d2_zero, d2_ones, d2_parity}, h2);
      dacc = d2_in_valid && (exp_q2.size() < D2);
      dpop = d2_out_ready && (exp_q2.size() > 0);
      r4 = 4'(ref_fn(d2_op, {4'h0, d2_a}, {4'h0, d2_b}));
      @(posedge clk); #1;
      if (dpop) begin void'(exp_q2.pop_front()); got++; end
      if (dacc) begin exp_q2.push_back({r4, (r4 == 4'h0), (r4 == 4'hF), ^r4}); sent++; end
    end
    d2_in_valid = 0; d2_out_ready = 0;
    chk("t4.sent", sent, 12);
    chk("t4.received", got, 12);
    chk("t4.final_count", d2_count, 0);

    // 5: asynchronous reset mid-stream
    cycle("t5.clr", 0, 0, 0, 1, 0, 0, 0);
    cycle("t5.load", 1, 3'd6, 1, 0, 8'h00, 8'h5A, 0);
    cycle("t5.fill", 1, 3'd1, 0, 0, 8'h11, 8'h22, 0);
    chk("t5.pre_count", count, 2);
    chk("t5.pre_acc", acc_q, 8'h5A);
    #2;
    rst_n = 0;
    #1;
    chk("t5.out_valid", out_valid, 0);
    chk("t5.y", y, 0);
    chk("t5.count", count, 0);
    chk("t5.acc_q", acc_q, 0);
    chk("t5.in_ready", in_ready, 0);
    exp_q.delete();
    model_acc = 8'h00;
    @(posedge clk); #1;
    rst_n = 1;
    cycle("t5.first", 1, 3'd4, 0, 0, 8'hF0, 8'h3C, 0);
    chk("t5.post_valid", out_valid, 1);
    chk("t5.post_y", y, 8'hCF);
    cycle("t5.end", 0, 0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Parametrised, registered successor to the single-bit gate primitives (AND/OR/NOT/NAND/NOR/XOR/XNOR).
- Applies one of eight bitwise functions, chosen per transaction by opcode, to two WIDTH-bit operands.
- Can chain results through an internal accumulator.
- Results, with reduction flags, are buffered in a DEPTH-entry output FIFO behind valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- DEPTH, 2, output FIFO entries (>=1).
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream transaction present.
- in_ready  output  1  unit can accept a transaction.
- op  input  3  function select (see Behaviour).
- acc_en  input  1  use accumulator as operand A; write result back to accumulator.
- acc_clr  input  1  synchronous accumulator clear.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- y  output  WIDTH  head result.
- zero  output  1  head result == 0.
- ones  output  1  head result all ones.
- parity  output  1  XOR-reduction of head result.
- acc_q  output  WIDTH  current accumulator value.
- count  output  CW  FIFO occupancy.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - count=0, out_valid=0, y=0, zero=0, ones=0, parity=0, acc_q=0, FIFO pointers=0.
  - in_ready=0 while rst_n is low.
- Opcode map: 0 AND, 1 OR, 2 NOT A, 3 NOT B, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
  - All functions are bitwise over WIDTH bits.
- Operand A = acc_en ? acc_q : a. Operand B is always b.
- in_ready = (count != DEPTH) while out of reset.
  - No combinational path from out_ready to in_ready.
- Accept: in_valid && in_ready at a rising edge.
  - The result and its flags (zero, ones, parity) are written into FIFO tail.
  - Latency 1: out_valid rises on the edge after the first accept into an empty FIFO.
- Pop: out_valid && out_ready at a rising edge advances the head.
  - y, zero, ones and parity always reflect the head entry.
  - When the FIFO is empty, these outputs are driven 0.
- Simultaneous accept and pop: count unchanged, both pointers advance.
  - This can occur only when 0 < count < DEPTH.
- Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- Accumulator update on an accepted transaction with acc_en=1: acc_q <= result.
  - acc_en=0: acc_q unchanged.
- acc_clr=1 at an edge: acc_q <= 0, regardless of any transfer.
  - acc_clr has priority over the acc_en write-back.
  - A transfer in the same cycle still enqueues its result, computed with the old acc_q.
- acc_clr does not affect FIFO contents or count.
- Inputs presented while in_ready=0 are ignored. No state changes.
- Entries, once enqueued, are immutable.
  - Holding out_ready=0 keeps y and the flags stable indefinitely.
- Reset asserted mid-operation: all buffered entries are discarded and the accumulator is cleared.
  - The first accept after reset release behaves as from power-up.

Test Plan (WIDTH=8, DEPTH=2 unless noted):
1. Sweep op 0..7 with a=8'hC3, b=8'hA5, out_ready=1.
   - Required y: 81, E7, 3C, 5A, 7E, 18, 66, 99, one per cycle, each 1 cycle after accept.
   - Required flags: parity=0 throughout; zero=0 and ones=0 for all entries.
2. out_ready=0, push three ops AND 8'hFF&8'hFF, XOR 8'h0F^8'h0F, OR.
   - First two accepted: count=2, in_ready=0, head y=FF with ones=1.
   - Third held.
   - Assert out_ready: y=FF, then y=00 with zero=1, then the OR result after acceptance.
3. Accumulator chain:
   - acc_clr, then acc_en=1, op=OR with b=01, 02, 04, 80: acc_q=87 and FIFO outputs 01, 03, 07, 87.
   - Then acc_clr with an accepted acc_en XOR b=FF: enqueued y=78, acc_q=00.
4. DEPTH=3, WIDTH=4: continuous accept with out_ready toggling every cycle over 12 transactions.
   - Scoreboard order exact, no loss or duplication.
   - count never exceeds 3; pointer wrap exercised.
5. Reset mid-stream with count=2, acc_q=5A: pull rst_n low asynchronously between edges.
   - Immediately: out_valid=0, y=0, count=0, acc_q=0, in_ready=0.
   - After release: the next accept produces out_valid on the following edge.
